// File: rtl/seven_seg_scan_if.sv
// Bundle between the application datapath and the seven-segment scan driver.
//
// Data side (driven by the application, master):
//   value     4*N_DIGITS hex nibbles, nibble k = digit k, digit 0 rightmost
//   dp_in     decimal point request per digit, 1 = lit
//   load      one-cycle strobe capturing value/dp_in into the shadow registers
//   digit_en  live per-digit enable, 0 = anode always off
//   blank_lz  1 = blank leading zeros
// Display side (driven by the scan driver, slave):
//   segments  active-low segments, bit order gfedcba (bit0 = a)
//   dp        active-low decimal point
//   anodes    active-low anode select
//   pending   shadow holds data not yet displayed
//   frame_done one-cycle pulse at each frame boundary
//
// Handshake: there is no backpressure. load is a pure strobe and is accepted
// on every rising edge it is high; a later load before the next frame
// boundary simply replaces the earlier shadow contents.
interface seven_seg_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  blank_lz;
    logic [6:0]            segments;
    logic                  dp;
    logic [N_DIGITS-1:0]   anodes;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output value, dp_in, load, digit_en, blank_lz,
        input  segments, dp, anodes, pending, frame_done
    );

    modport slave (
        input  value, dp_in, load, digit_en, blank_lz,
        output segments, dp, anodes, pending, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed, double-buffered seven-segment driver for a common-anode
// display bank.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        seven_seg_scan_if slave: data/strobe in, segment/anode pins out
//   phase_dbg  current slot phase (0 = BLANK, 1 = SHOW)
//
// Each digit slot lasts REFRESH_DIV cycles; the first BLANK_CYCLES of a slot
// keep every anode off so the previous digit's pattern cannot ghost onto the
// next anode. New data is staged in a shadow register and only copied into
// the active register at a frame boundary, so a frame never mixes two loads.
// All pin outputs are registered and update together on one edge.
module seven_seg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seven_seg_scan_if.slave  bus,
    output logic             phase_dbg
);
    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [TW-1:0]       TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_ONE  = N_DIGITS'(1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    // With no blank gap a slot is SHOW from its first tick.
    localparam phase_t PH_FIRST = (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;

    phase_t                phase;
    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [4*N_DIGITS-1:0] active_val;
    logic [N_DIGITS-1:0]   active_dp;

    logic       boundary;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_en;
    logic       upper_nz;
    logic       lz_blank;
    logic       lit;

    assign phase_dbg = (phase == PH_SHOW);
    assign boundary  = (tick == TICK_LAST) && (idx == IDX_LAST);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Select the current digit's data, and find whether any nibble at or
    // above the current position is non-zero (leading-zero detection).
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        upper_nz = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IW'(k) == idx) begin
                cur_nib = active_val[k*4 +: 4];
                cur_dp  = active_dp[k];
                cur_en  = bus.digit_en[k];
            end
            if ((IW'(k) >= idx) && (active_val[k*4 +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked so that a zero value still shows "0".
    assign lz_blank = bus.blank_lz && (idx != '0) && !upper_nz;
    // A blanked digit still lights if it has to show its decimal point.
    assign lit      = (phase == PH_SHOW) && cur_en && !(lz_blank && !cur_dp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase          <= PH_FIRST;
            tick           <= '0;
            idx            <= '0;
            shadow_val     <= '0;
            shadow_dp      <= '0;
            active_val     <= '0;
            active_dp      <= '0;
            bus.pending    <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.segments   <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.anodes     <= '1;
        end else begin
            // Slot phase and scan position.
            if (tick == TICK_LAST) begin
                tick  <= '0;
                phase <= PH_FIRST;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
                if ((BLANK_CYCLES > 0) && (tick == BLANK_LAST)) begin
                    phase <= PH_SHOW;
                end
            end

            bus.frame_done <= boundary;

            // Double buffer. A load on the boundary cycle bypasses the shadow
            // so it is shown in the very next frame with nothing left pending.
            if (bus.load && boundary) begin
                shadow_val  <= bus.value;
                shadow_dp   <= bus.dp_in;
                active_val  <= bus.value;
                active_dp   <= bus.dp_in;
                bus.pending <= 1'b0;
            end else if (bus.load) begin
                shadow_val  <= bus.value;
                shadow_dp   <= bus.dp_in;
                bus.pending <= 1'b1;
            end else if (boundary) begin
                if (bus.pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                end
                bus.pending <= 1'b0;
            end

            // Pins: segments, dp and anodes always switch on the same edge.
            if (lit) begin
                bus.anodes   <= ~(ANODE_ONE << idx);
                bus.segments <= lz_blank ? 7'h7F : seg_decode(cur_nib);
                bus.dp       <= ~cur_dp;
            end else begin
                bus.anodes   <= '1;
                bus.segments <= 7'h7F;
                bus.dp       <= 1'b1;
            end
        end
    end
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode display bank. It scans N_DIGITS hex digits from a packed nibble bus and adds double-buffered (tear-free) updates, per-digit enable and decimal point, leading-zero blanking, and an anti-ghosting blank gap between digit slots. It sits between the application datapath and the top-level segment/anode pins.

## Interface
- N_DIGITS, 8, number of digits scanned (2..16)
- REFRESH_DIV, 100000, clock cycles per digit slot (≥ 2)
- BLANK_CYCLES, 1, cycles at the start of each slot with all anodes off (0 ≤ BLANK_CYCLES < REFRESH_DIV)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- value  in  4*N_DIGITS  hex nibbles; nibble k = digit k, with digit 0 rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- load  in  1  one-cycle strobe that captures value and dp_in into the shadow registers
- digit_en  in  N_DIGITS  live per-digit enable; 0 = anode always off
- blank_lz  in  1  1 = blank leading zeros
- segments  out  7  active-low, bit order gfedcba (bit0 = a)
- dp  out  1  active-low decimal point
- anodes  out  N_DIGITS  active-low anode select
- pending  out  1  shadow holds data not yet displayed
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Slot counter tick 0..REFRESH_DIV-1 increments every cycle. At tick = REFRESH_DIV-1, tick wraps to 0 and digit index idx advances; idx wraps from N_DIGITS-1 to 0.
- Frame boundary: tick = REFRESH_DIV-1 and idx = N_DIGITS-1. One frame = N_DIGITS*REFRESH_DIV cycles.
- Load path: load=1 sets shadow ← value and dp_in, and sets pending ← 1.
- Commit: at a frame boundary with pending=1, active ← shadow and pending ← 0.
- Load in the same cycle as a boundary: active ← value/dp_in directly and pending = 0.
- Active registers change only at frame boundaries, so a frame never mixes two loads.
- Leading-zero blanking: digit k>0 is blanked when blank_lz=1 and active nibbles k..N_DIGITS-1 are all 0. Digit 0 is never blanked by this rule. A blanked digit shows its dp if requested: segments = 7'h7F, dp per active dp bit.
- Anode for idx:
  - all anodes off when tick < BLANK_CYCLES, or digit_en[idx]=0, or the digit is blanked with its dp bit = 0;
  - otherwise only anodes[idx] = 0.
- Decode, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- State machine, per-slot phase: BLANK (tick < BLANK_CYCLES) → SHOW (remaining ticks) → next slot's BLANK. With BLANK_CYCLES=0 the phase is SHOW only.

## Timing
- Reset (reset=0, asynchronous) forces tick=0, idx=0, shadow=0, active=0, pending=0, frame_done=0, segments=7'h7F, dp=1, anodes=all 1.
- Release is synchronous to the next edge. The first slot after release is idx 0 at tick 0.
- All outputs are registered with 1-cycle latency from the internal (tick, idx, active) state: segments, dp and anodes for slot state S appear the cycle after S.
- segments, dp and anodes change on the same edge, so there is no cycle where a new digit is driven on the old anode.
- frame_done is high the cycle after the boundary cycle, aligned with the commit becoming visible in internal state.
- pending rises the cycle after load and falls the cycle after commit.
- digit_en and blank_lz are sampled live: their effect appears 1 cycle after a change.
- Reset mid-frame drops all outputs to the reset values immediately and discards both shadow and active data.

## Test plan
All scenarios use N_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1.
- **Reset:** reset=0 for 3 cycles → segments=7F, dp=1, anodes=FF, pending=0. After release, the first slot shows digit 0 = "0": anodes=FE, segments=40 during ticks 1..3.
- **Load and commit:** load value=32'h0000_0069, blank_lz=0, digit_en=FF → pending=1 until the next boundary, then frame_done pulses. Slot 0 shows 10 on FE, slot 1 shows 02 on FD, slots 2..7 show 40. Each slot has 1 blank cycle with anodes=FF.
- **Leading-zero blanking:** same value with blank_lz=1 → digits 2..7 have anodes=FF. value=0 → only digit 0 lit, showing 40.
- **Tear-free update:** load 32'hFFFF_FFFF mid-frame, then 32'hA5A5_A5A5 before the boundary → the current frame is unchanged and the next frame shows only A5A5A5A5 (A→08, 5→12). Load coincident with the boundary cycle → displayed in the next frame, pending stays 0.
- **dp and digit_en:** dp_in=8'h04 and digit_en=8'hF7 → digit 2 has dp=0 during its slot and digit 3 is never lit. A blank_lz-blanked digit with dp set lights its anode with segments=7F, dp=0.
- **Async reset mid-slot:** reset pulsed low between edges during idx 5 → outputs reach reset values without a clock edge, and the scan restarts at idx 0 after release.
